// File: rtl/uart_rx_param_if.sv
// Received-word handshake bundle: data, valid/ready and per-word error flags.
// The receiver drives the master side and the consumer drives the slave side.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with a valid/ready holding register and parity/frame/overrun flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority centre sampling (adds one clock of latency).
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rxd,
    uart_rx_param_if.master rx_if,
    output logic            busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_flag_q, par_flag_d;
    logic                 frm_flag_q, frm_flag_d;
    logic                 sync1_q, sync1_d;
    logic                 rxs_q, rxs_d;
    logic                 rxs_prev_q, rxs_prev_d;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;

    logic fall, strobe, bit_end, smp, par_exp, done;

    // Synchroniser flops reset high so a reset release never looks like a start edge.
    always_comb begin
        sync1_d    = rxd;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
        end
    end

    assign fall = rxs_prev_q & ~rxs_q;

`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_AT = OVERSAMPLE / 2 + 1;
    logic [1:0] hist_q, hist_d;

    always_comb hist_d = {hist_q[0], rxs_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_q <= 2'b11;
        else      hist_q <= hist_d;
    end

    // hist_q holds rxs from the two preceding ticks, so the vote spans centre-1..centre+1.
    assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
    localparam int SAMPLE_AT = OVERSAMPLE / 2;
    assign smp = rxs_q;
`endif

    assign strobe  = (cnt_q == CW'(SAMPLE_AT));
    assign bit_end = (cnt_q == CNT_LAST);
    assign par_exp = (PARITY == 1) ? ~^shreg_q : ^shreg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_flag_q <= par_flag_d;
            frm_flag_q <= frm_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_flag_d = par_flag_q;
        frm_flag_d = frm_flag_q;
        if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    par_flag_d = 1'b0;
                    frm_flag_d = 1'b0;
                end
            end
            S_START: begin
                if (strobe && smp) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (strobe) shreg_d = {smp, shreg_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (strobe) par_flag_d = (smp != par_exp);
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (strobe && !smp) frm_flag_d = 1'b1;
                // Leave straight from the last centre so a start edge half a bit later is caught.
                if (done)         state_d   = S_IDLE;
                else if (bit_end) bit_cnt_d = bit_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_STOP) && strobe && (bit_cnt_q == STOP_LAST);
    end

    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        overrun_err_d = overrun_err_q;
        if (done) begin
            rx_data_d     = shreg_q;
            rx_valid_d    = 1'b1;
            parity_err_d  = (PARITY != 0) && par_flag_q;
            frame_err_d   = frm_flag_d;
            overrun_err_d = rx_valid_q & ~rx_if.rx_ready;
        end else if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.rx_valid    = rx_valid_q;
    assign rx_if.parity_err  = parity_err_q;
    assign rx_if.frame_err   = frame_err_q;
    assign rx_if.overrun_err = overrun_err_q;
endmodule
